agc_timer_gen: RTL and testbench

Master timing generator that sits directly upstream of the A1 scaler. From the single master clock it produces the four-phase rotation (P01–P04) and the twelve-pulse time ring (T01–T12) that define one memory cycle time (MCT). It also generates the free-running scaler drive FS01_ with F01A/F01B edge strobes, and implements the monitor stop / single-step handshake (MSTP/MSTRT).

---
 rtl/agc_timer_gen_if.sv | 27 ++
 rtl/agc_timer_gen.sv | 158 +++++++++++++++
 tb/tb_agc_timer_gen.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/agc_timer_gen_if.sv
// Bundle of the monitor handshake inputs and all timing outputs of the
// AGC master timing generator.
interface agc_timer_gen_if;
  logic MSTP;
  logic MSTRT;
  logic P01, P02, P03, P04;
  logic T01, T02, T03, T04, T05, T06, T07, T08, T09, T10, T11, T12;
  logic MCTEND;
  logic STOPPED;
  logic FS01_;
  logic F01A;
  logic F01B;

  modport master (
    input  MSTP, MSTRT,
    output P01, P02, P03, P04,
    output T01, T02, T03, T04, T05, T06, T07, T08, T09, T10, T11, T12,
    output MCTEND, STOPPED, FS01_, F01A, F01B
  );

  modport slave (
    output MSTP, MSTRT,
    input  P01, P02, P03, P04,
    input  T01, T02, T03, T04, T05, T06, T07, T08, T09, T10, T11, T12,
    input  MCTEND, STOPPED, FS01_, F01A, F01B
  );
endinterface

// File: rtl/agc_timer_gen.sv
// AGC master timing generator: four-phase rotation, twelve-pulse time ring
// (one MCT = 48 clocks), monitor stop/single-step, and the free-running
// FS01_ scaler drive with its edge strobes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_START | just out of reset; next cycle is T01/P01
// ST_RUN   | phase and ring advancing
// ST_HALT  | ring parked between MCTs, waiting for resume or single step
module agc_timer_gen #(
  parameter int GATE_DELAY = 20,
  parameter int FS01_HALF  = 10
) (
  input  logic             CLOCK,
  input  logic             rst,
  agc_timer_gen_if.master  bus
);

  if (FS01_HALF < 2 || FS01_HALF > 255 || GATE_DELAY < 0) begin : g_bad_param
    $error("agc_timer_gen: FS01_HALF must be 2..255 and GATE_DELAY non-negative");
  end

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [7:0] PRESC_LAST = 8'(FS01_HALF - 1);

  state_t      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [3:0]  ring_q, ring_d;
  logic [3:0]  p_q, p_d;
  logic [11:0] t_q, t_d;
  logic        mctend_q, mctend_d;
  logic        stopped_q, stopped_d;
  logic [7:0]  presc_q, presc_d;
  logic        fs01_q, fs01_d;
  logic        f01a_q, f01a_d;
  logic        f01b_q, f01b_d;
  logic        last_cycle;
  logic        presc_wrap;

  assign last_cycle = (phase_q == 2'd3) && (ring_q == 4'd11);
  assign presc_wrap = (presc_q == PRESC_LAST);

  // Ring next-state: stop is only honoured at the MCT boundary.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    ring_d  = ring_q;
    case (state_q)
      ST_START: begin
        state_d = ST_RUN;
        phase_d = 2'd0;
        ring_d  = 4'd0;
      end
      ST_RUN: begin
        if (last_cycle) begin
          phase_d = 2'd0;
          ring_d  = 4'd0;
          state_d = bus.MSTP ? ST_HALT : ST_RUN;
        end else begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            ring_d = ring_q + 4'd1;
          end
        end
      end
      ST_HALT: begin
        if (!bus.MSTP || bus.MSTRT) begin
          state_d = ST_RUN;
          phase_d = 2'd0;
          ring_d  = 4'd0;
        end
      end
      default: begin
        state_d = ST_START;
        phase_d = 2'd0;
        ring_d  = 4'd0;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    p_d       = '0;
    t_d       = '0;
    mctend_d  = 1'b0;
    stopped_d = (state_d == ST_HALT);
    if (state_d == ST_RUN) begin
      p_d[phase_d] = 1'b1;
      t_d[ring_d]  = 1'b1;
      mctend_d     = (phase_d == 2'd3) && (ring_d == 4'd11);
    end
  end

  // Prescaler keeps counting through halts; strobes mark the FS01_ edges.
  always_comb begin
    presc_d = presc_wrap ? 8'd0 : presc_q + 8'd1;
    fs01_d  = presc_wrap ? ~fs01_q : fs01_q;
    f01a_d  = presc_wrap &  fs01_q;
    f01b_d  = presc_wrap & ~fs01_q;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLOCK) begin
    if (!rst) begin
      state_q   <= ST_START;
      phase_q   <= 2'd0;
      ring_q    <= 4'd0;
      p_q       <= '0;
      t_q       <= '0;
      mctend_q  <= 1'b0;
      stopped_q <= 1'b0;
      presc_q   <= 8'd0;
      fs01_q    <= 1'b1;
      f01a_q    <= 1'b0;
      f01b_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      ring_q    <= ring_d;
      p_q       <= p_d;
      t_q       <= t_d;
      mctend_q  <= mctend_d;
      stopped_q <= stopped_d;
      presc_q   <= presc_d;
      fs01_q    <= fs01_d;
      f01a_q    <= f01a_d;
      f01b_q    <= f01b_d;
    end
  end

  assign bus.P01 = p_q[0];
  assign bus.P02 = p_q[1];
  assign bus.P03 = p_q[2];
  assign bus.P04 = p_q[3];
  assign bus.T01 = t_q[0];
  assign bus.T02 = t_q[1];
  assign bus.T03 = t_q[2];
  assign bus.T04 = t_q[3];
  assign bus.T05 = t_q[4];
  assign bus.T06 = t_q[5];
  assign bus.T07 = t_q[6];
  assign bus.T08 = t_q[7];
  assign bus.T09 = t_q[8];
  assign bus.T10 = t_q[9];
  assign bus.T11 = t_q[10];
  assign bus.T12 = t_q[11];
  assign bus.MCTEND  = mctend_q;
  assign bus.STOPPED = stopped_q;
  assign bus.FS01_   = fs01_q;
  assign bus.F01A    = f01a_q;
  assign bus.F01B    = f01b_q;

endmodule

// File: tb/tb_agc_timer_gen.sv
// Bench for agc_timer_gen: directed scenarios, a position-based model of the
// MCT and prescaler checked every cycle, and literal expectations.
module tb_agc_timer_gen;
  localparam int HALF = 10;
  localparam int M_PRE = 0, M_RUN = 1, M_HALT = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  logic cmp_en = 1'b0;

  agc_timer_gen_if bus();

  agc_timer_gen #(.GATE_DELAY(20), .FS01_HALF(HALF)) u_dut (
    .CLOCK (clk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [3:0]  dut_p;
  logic [11:0] dut_t;
  assign dut_p = {bus.P04, bus.P03, bus.P02, bus.P01};
  assign dut_t = {bus.T12, bus.T11, bus.T10, bus.T09, bus.T08, bus.T07,
                  bus.T06, bus.T05, bus.T04, bus.T03, bus.T02, bus.T01};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait expired at %0t", name, $time);
  endtask

  // Model: position 0..47 within the MCT, plus cycles since reset release.
  int m_state = M_PRE;
  int m_pos   = 0;
  int m_n     = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_state = M_PRE;
      m_pos   = 0;
      m_n     = 0;
    end else begin
      m_n++;
      case (m_state)
        M_PRE:  begin m_state = M_RUN; m_pos = 0; end
        M_RUN: begin
          if (m_pos == 47) begin
            m_pos = 0;
            if (bus.MSTP) m_state = M_HALT;
          end else begin
            m_pos++;
          end
        end
        default: begin
          if (!bus.MSTP || bus.MSTRT) begin
            m_state = M_RUN;
            m_pos   = 0;
          end
        end
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [3:0]  exp_p;
      logic [11:0] exp_t;
      logic        run;
      run   = (m_state == M_RUN);
      exp_p = run ? (4'b0001 << (m_pos % 4)) : 4'b0000;
      exp_t = run ? (12'b1 << (m_pos / 4)) : 12'b0;
      chk("model_p", 32'(dut_p), 32'(exp_p));
      chk("model_t", 32'(dut_t), 32'(exp_t));
      chk("model_mctend", 32'(bus.MCTEND), 32'(run && m_pos == 47));
      chk("model_stopped", 32'(bus.STOPPED), 32'(m_state == M_HALT));
      chk("model_fs01", 32'(bus.FS01_), 32'(((m_n / HALF) % 2) == 0));
      chk("model_f01a", 32'(bus.F01A), 32'(m_n > 0 && (m_n % (2*HALF)) == HALF));
      chk("model_f01b", 32'(bus.F01B), 32'(m_n > 0 && (m_n % (2*HALF)) == 0));
      chk("ab_exclusive", 32'(bus.F01A & bus.F01B), 32'd0);
      if (run) begin
        chk("onehot_p", 32'($onehot(dut_p)), 32'd1);
        chk("onehot_t", 32'($onehot(dut_t)), 32'd1);
      end
    end
  end

  task automatic wait_pos(input int target);
    int k;
    for (k = 0; k < 500 && !(m_state == M_RUN && m_pos == target); k++) @(negedge clk);
    if (!(m_state == M_RUN && m_pos == target)) timeout("wait_pos");
  endtask

  task automatic wait_halt();
    int k;
    for (k = 0; k < 500 && m_state != M_HALT; k++) @(negedge clk);
    if (m_state != M_HALT) timeout("wait_halt");
  endtask

  initial begin
    int cnt;
    int fa_cnt;
    logic seen_stop;
    rst = 1'b0;
    bus.MSTP = 1'b0;
    bus.MSTRT = 1'b0;
    @(posedge clk);
    #1 cmp_en = 1'b1;

    // Reset and free run
    repeat (3) @(negedge clk);
    chk("reset_p", 32'(dut_p), 32'd0);
    chk("reset_t", 32'(dut_t), 32'd0);
    chk("reset_fs01", 32'(bus.FS01_), 32'd1);
    chk("reset_stopped", 32'(bus.STOPPED), 32'd0);
    rst = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1)  begin chk("c1_p", 32'(dut_p), 32'h1); chk("c1_t", 32'(dut_t), 32'h1); end
      if (c == 9)  chk("c9_fs01", 32'(bus.FS01_), 32'd1);
      if (c == 10) begin chk("c10_f01a", 32'(bus.F01A), 32'd1); chk("c10_fs01", 32'(bus.FS01_), 32'd0); end
      if (c == 20) begin chk("c20_f01b", 32'(bus.F01B), 32'd1); chk("c20_fs01", 32'(bus.FS01_), 32'd1); end
      if (c == 30) chk("c30_f01a", 32'(bus.F01A), 32'd1);
      if (c == 48) begin
        chk("c48_p", 32'(dut_p), 32'h8);
        chk("c48_t", 32'(dut_t), 32'h800);
        chk("c48_mctend", 32'(bus.MCTEND), 32'd1);
      end
      if (c == 49) begin chk("c49_p", 32'(dut_p), 32'h1); chk("c49_t", 32'(dut_t), 32'h1); end
    end

    // Stop at the MCT boundary, requested at T05
    wait_pos(16);
    chk("t05_seen", 32'(dut_t), 32'h010);
    bus.MSTP = 1'b1;
    seen_stop = 1'b0;
    for (int k = 0; k < 100 && !bus.MCTEND; k++) @(negedge clk);
    chk("stop_mctend", 32'(bus.MCTEND), 32'd1);
    chk("stop_not_yet", 32'(bus.STOPPED), 32'd0);
    @(negedge clk);
    chk("stop_stopped", 32'(bus.STOPPED), 32'd1);
    chk("stop_p_low", 32'(dut_p), 32'd0);
    chk("stop_t_low", 32'(dut_t), 32'd0);
    repeat (100) @(negedge clk);
    chk("stop_hold100", 32'(bus.STOPPED), 32'd1);

    // Single step with MSTP held high; extra MSTRT at T06 is ignored
    bus.MSTRT = 1'b1;
    @(negedge clk);
    bus.MSTRT = 1'b0;
    chk("step_p", 32'(dut_p), 32'h1);
    chk("step_t", 32'(dut_t), 32'h1);
    cnt = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.MSTRT) bus.MSTRT = 1'b0;
      if (bus.STOPPED) begin
        seen_stop = 1'b1;
        break;
      end
      cnt++;
      if (cnt == 21) begin
        chk("step_t06", 32'(dut_t), 32'h020);
        bus.MSTRT = 1'b1;
      end
    end
    if (!seen_stop) timeout("step_end");
    chk("step_len", 32'(cnt), 32'd48);

    // 200-cycle halt: prescaler cadence carries on
    fa_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.F01A) fa_cnt++;
    end
    chk("halt_f01a_count", 32'(fa_cnt), 32'd10);
    chk("halt_still", 32'(bus.STOPPED), 32'd1);

    // Resume
    bus.MSTP = 1'b0;
    @(negedge clk);
    chk("resume_p", 32'(dut_p), 32'h1);
    chk("resume_t", 32'(dut_t), 32'h1);
    repeat (100) @(negedge clk);
    chk("resume_running", 32'(bus.STOPPED), 32'd0);

    // Reset at T07/P03 while running
    wait_pos(26);
    chk("t07p03_t", 32'(dut_t), 32'h040);
    chk("t07p03_p", 32'(dut_p), 32'h4);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_p", 32'(dut_p), 32'd0);
    chk("mrst_t", 32'(dut_t), 32'd0);
    chk("mrst_fs01", 32'(bus.FS01_), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1)  begin chk("mrst_c1_p", 32'(dut_p), 32'h1); chk("mrst_c1_t", 32'(dut_t), 32'h1); end
      if (c == 9)  chk("mrst_c9_f01a", 32'(bus.F01A), 32'd0);
      if (c == 10) chk("mrst_c10_f01a", 32'(bus.F01A), 32'd1);
    end

    // Reset while halted
    bus.MSTP = 1'b1;
    wait_halt();
    chk("hrst_pre_stopped", 32'(bus.STOPPED), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("hrst_stopped", 32'(bus.STOPPED), 32'd0);
    chk("hrst_p", 32'(dut_p), 32'd0);
    chk("hrst_fs01", 32'(bus.FS01_), 32'd1);
    bus.MSTP = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("hrst_c1_p", 32'(dut_p), 32'h1);
    chk("hrst_c1_t", 32'(dut_t), 32'h1);
    repeat (60) @(negedge clk);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
